// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC/ROM reader feeding a small fetch queue with valid/ready output and redirect.
module instruction_fetch_unit #(
  parameter int          ROM_ENTRIES    = 16,
  parameter int          ROM_ADDR_WIDTH = 4,
  parameter int          FQ_DEPTH       = 4,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]               rom_instruction,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_instruction,
  output logic [31:0]               out_pc,
  output logic                      fetch_done
);
  localparam int          AW     = $clog2(FQ_DEPTH);
  localparam int          CW     = AW + 1;
  localparam logic [31:0] END_PC = 32'(ROM_ENTRIES * 4);
  typedef enum logic {FETCH, DONE} state_e;
  state_e          state_q;
  logic [31:0]     pc_q, inflight_pc_q;
  logic            inflight_q;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_q, rd_q;
  logic [31:0]     fq_pc_q  [FQ_DEPTH];
  logic [31:0]     fq_ins_q [FQ_DEPTH];
  logic            issue, push, pop;
  assign rom_addr        = pc_q[ROM_ADDR_WIDTH+1:2];
  assign out_valid       = (count_q != '0) && !redirect_valid;
  assign pop             = out_valid && out_ready;
  assign push            = inflight_q && !redirect_valid;
  // Slots are reserved at issue time, so a pending ROM word always has room.
  assign issue           = (state_q == FETCH) && (pc_q < END_PC) && !redirect_valid &&
                           ((count_q + CW'(inflight_q)) < CW'(FQ_DEPTH));
  assign count_d         = count_q + CW'(push) - CW'(pop);
  assign out_instruction = out_valid ? fq_ins_q[rd_q] : '0;
  assign out_pc          = out_valid ? fq_pc_q[rd_q] : '0;
  assign fetch_done      = (state_q == DONE) && (count_q == '0) && !inflight_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      wr_q          <= '0;
      rd_q          <= '0;
    end else if (redirect_valid) begin
      state_q    <= FETCH;
      pc_q       <= redirect_pc & ~32'h3;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= (state_q == FETCH && pc_q >= END_PC) ? DONE : state_q;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd4;
      end
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      fq_pc_q[wr_q]  <= inflight_pc_q;
      fq_ins_q[wr_q] <= rom_instruction;
    end
  end
endmodule
